// File: rtl/mario_pkg.sv
// Shared constants and types for the Mario game-logic blocks.
// Holds field geometry, the pause state code and the mushroom controller FSM states.
package mario_pkg;

    localparam int BW       = 240;
    localparam int MGMW     = 16;
    localparam int FLOOR_R  = 110;
    localparam int GROUND_R = FLOOR_R + 50 - MGMW;

    localparam logic [3:0] ST_PAUSE = 4'b1010;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mogu_state_t;

endpackage

// File: rtl/mogu_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pre-draw mushroom wave patterns.
// Shifts toward the MSB with the feedback bit entering at bit 0.
module mogu_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/mogu_ctrl.sv
// Mushroom wave controller: draws the next wave pattern, relaunches the four
// mushrooms on each wave start and walks the live ones across the field on frame ticks.
module mogu_ctrl #(
    parameter int         BW       = mario_pkg::BW,
    parameter int         MGMW     = mario_pkg::MGMW,
    parameter int         GROUND_R = mario_pkg::GROUND_R,
    parameter int         SPAWN_C0 = 200,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        pause,
    input  logic        inspire,
    input  logic [3:0]  alive,
    output logic [3:0]  MOGU,
    output logic [10:0] C1,
    output logic [10:0] C2,
    output logic [10:0] C3,
    output logic [10:0] C4,
    output logic [10:0] R1,
    output logic [10:0] R2,
    output logic [10:0] R3,
    output logic [10:0] R4,
    output logic [3:0]  dir,
    output logic [7:0]  wave
);

    import mario_pkg::*;

    mogu_state_t state;
    logic [7:0]  lfsr;
    logic        insp_d;
    logic [10:0] row_q;
    logic [10:0] col     [4];
    logic [10:0] col_nxt [4];
    logic        dir_q   [4];
    logic        dir_nxt [4];
    logic [10:0] step;
    logic        launch;
    logic        step_en;
    logic [3:0]  draw;

    mogu_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr)
    );

    assign launch  = inspire && !insp_d && !pause;
    assign step_en = (state == RUN) && tick && !pause && !launch;
    assign step    = 11'd2 + 11'(wave >= 8'd4) + 11'(wave >= 8'd8);
    assign draw    = (lfsr[3:0] == 4'd0) ? 4'b0001 : lfsr[3:0];

    // Per-mushroom wall check and move; walls hold the column and flip direction.
    for (genvar i = 0; i < 4; i++) begin : g_mush
        logic [10:0] spawn;
        logic        at_left;
        logic        at_right;
        logic        mv;

        assign spawn    = 11'(SPAWN_C0 - 40 * i);
        assign at_left  = col[i] < (11'd1 + step);
        assign at_right = (col[i] + 11'(MGMW) + step) > 11'(BW - 1);
        assign mv       = step_en && alive[i];

        assign col_nxt[i] = launch   ? spawn :
                            !mv      ? col[i] :
                            dir_q[i] ? (at_left  ? col[i] : col[i] - step) :
                                       (at_right ? col[i] : col[i] + step);

        assign dir_nxt[i] = launch   ? 1'b1 :
                            !mv      ? dir_q[i] :
                            dir_q[i] ? !at_left : at_right;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            MOGU   <= SEED[3:0];
            wave   <= 8'd0;
            insp_d <= 1'b0;
            row_q  <= 11'(GROUND_R);
            for (int i = 0; i < 4; i++) begin
                col[i]   <= 11'(SPAWN_C0 - 40 * i);
                dir_q[i] <= 1'b1;
            end
        end else begin
            insp_d <= inspire;
            row_q  <= 11'(GROUND_R);
            for (int i = 0; i < 4; i++) begin
                col[i]   <= col_nxt[i];
                dir_q[i] <= dir_nxt[i];
            end
            if (launch) begin
                state <= RUN;
                MOGU  <= draw;
                if (wave != 8'hFF) wave <= wave + 8'd1;
            end else if (state == RUN && alive == 4'd0) begin
                state <= IDLE;
            end
        end
    end

    assign C1  = col[0];
    assign C2  = col[1];
    assign C3  = col[2];
    assign C4  = col[3];
    assign R1  = row_q;
    assign R2  = row_q;
    assign R3  = row_q;
    assign R4  = row_q;
    assign dir = {dir_q[3], dir_q[2], dir_q[1], dir_q[0]};

endmodule

// File: tb/tb_mogu_ctrl.sv
// Randomized bench for mogu_ctrl against a behavioural wave/position model.
// Directed phases cover launch, walls, pause, zero-pattern substitution, wave-end and saturation.
module tb_mogu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        pause = 1'b0;
    logic        inspire = 1'b0;
    logic [3:0]  alive = 4'd0;
    logic [3:0]  MOGU;
    logic [10:0] C1, C2, C3, C4, R1, R2, R3, R4;
    logic [3:0]  dir;
    logic [7:0]  wave;

    int total = 0;
    int bad = 0;

    mogu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .pause(pause), .inspire(inspire),
        .alive(alive), .MOGU(MOGU),
        .C1(C1), .C2(C2), .C3(C3), .C4(C4),
        .R1(R1), .R2(R2), .R3(R3), .R4(R4),
        .dir(dir), .wave(wave)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] m_lfsr;
    logic [3:0] m_mogu;
    int         m_c [4];
    logic [3:0] m_dir;
    int         m_wave;
    bit         m_run;
    bit         m_insp_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr   = 8'hA5;
        m_mogu   = 4'b0101;
        for (int i = 0; i < 4; i++) m_c[i] = 200 - 40 * i;
        m_dir    = 4'b1111;
        m_wave   = 0;
        m_run    = 0;
        m_insp_d = 0;
    endtask

    task automatic model_edge();
        int  st;
        bit  launch;
        launch = inspire && !m_insp_d && !pause;
        st = 2 + ((m_wave >= 4) ? 1 : 0) + ((m_wave >= 8) ? 1 : 0);
        if (launch) begin
            m_mogu = (m_lfsr[3:0] == 0) ? 4'b0001 : m_lfsr[3:0];
            for (int i = 0; i < 4; i++) m_c[i] = 200 - 40 * i;
            m_dir  = 4'b1111;
            m_wave = (m_wave < 255) ? m_wave + 1 : 255;
            m_run  = 1;
        end else if (m_run) begin
            if (alive == 0) begin
                m_run = 0;
            end else if (tick && !pause) begin
                for (int i = 0; i < 4; i++) begin
                    if (alive[i]) begin
                        if (m_dir[i]) begin
                            if (m_c[i] < 1 + st) m_dir[i] = 1'b0;
                            else m_c[i] = m_c[i] - st;
                        end else begin
                            if (m_c[i] + 16 + st > 239) m_dir[i] = 1'b1;
                            else m_c[i] = m_c[i] + st;
                        end
                    end
                end
            end
        end
        m_insp_d = inspire;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic check_all();
        chk("C1", 32'(C1), 32'(m_c[0]));
        chk("C2", 32'(C2), 32'(m_c[1]));
        chk("C3", 32'(C3), 32'(m_c[2]));
        chk("C4", 32'(C4), 32'(m_c[3]));
        chk("R1", 32'(R1), 32'd144);
        chk("R4", 32'(R4), 32'd144);
        chk("dir", 32'(dir), 32'(m_dir));
        chk("MOGU", 32'(MOGU), 32'(m_mogu));
        chk("wave", 32'(wave), 32'(m_wave));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int n;
        logic [10:0] hold_c1;

        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_all();
        chk("rst_MOGU", 32'(MOGU), 32'd5);

        // First wave with mushrooms 1 and 3 alive
        alive = 4'b0101;
        inspire = 1'b1;
        cyc();
        chk("launch_wave", 32'(wave), 32'd1);
        chk("launch_nz", 32'(MOGU != 4'd0), 32'd1);
        inspire = 1'b0;
        repeat (10) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
        chk("C1_after10", 32'(C1), 32'd180);
        chk("C3_after10", 32'(C3), 32'd100);
        chk("C2_frozen", 32'(C2), 32'd160);

        // Mushroom 1 alone bounces off both walls
        alive = 4'b0001;
        tick = 1'b1;
        repeat (250) cyc();
        tick = 1'b0;

        // Pause freezes motion and swallows the inspire edge
        pause = 1'b1;
        hold_c1 = C1;
        repeat (5) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
        inspire = 1'b1; cyc();
        chk("pause_C1", 32'(C1), 32'(hold_c1));
        chk("pause_wave", 32'(wave), 32'd1);
        pause = 1'b0;
        cyc();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
        chk("pause_wave2", 32'(wave), 32'd1);

        // Launch timed so the LFSR low nibble is zero
        inspire = 1'b0; cyc();
        n = 0;
        while (m_lfsr[3:0] != 4'd0 && n < 300) begin
            cyc();
            n++;
        end
        chk("lfsr_zero_found", 32'(n < 300), 32'd1);
        inspire = 1'b1; cyc();
        chk("zero_sub", 32'(MOGU), 32'd1);
        inspire = 1'b0;

        // All dead ends the wave; later ticks do nothing
        alive = 4'b0000; cyc();
        alive = 4'b1111;
        hold_c1 = C1;
        tick = 1'b1;
        repeat (6) cyc();
        tick = 1'b0;
        chk("idle_C1", 32'(C1), 32'(hold_c1));

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(39) == 0) inspire = ~inspire;
            if ($urandom_range(19) == 0) pause = ~pause;
            if ($urandom_range(49) == 0) alive = 4'($urandom_range(15));
            tick = ($urandom_range(2) == 0);
            cyc();
        end

        // Asynchronous reset in the middle of a wave
        inspire = 1'b0; pause = 1'b0; alive = 4'b1111; tick = 1'b1;
        cyc();
        inspire = 1'b1; cyc();
        inspire = 1'b0;
        repeat (7) cyc();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick = 1'b0;
        cyc();

        // Wave counter saturation
        alive = 4'b1010;
        repeat (260) begin
            inspire = 1'b1; cyc();
            inspire = 1'b0; tick = 1'($urandom_range(1)); cyc();
        end
        chk("wave_sat", 32'(wave), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
